// File: rtl/ysyx_ifu_seq.sv
// ysyx_ifu_seq -- fetch-side sequencer.
//
// Owns the fetch PC and keeps at most one I-cache request in flight.
// Responses go into a small FIFO that feeds the decoder. A redirect from
// writeback clears the FIFO, moves the PC to the corrected target and
// toggles an epoch bit. Any response still in flight then carries the old
// epoch and is dropped. A fence.i redirect also invalidates the I-cache
// before fetching resumes.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   wbu_*                        redirect channel from writeback
//                                (flush_pipe qualifies all other fields)
//   req_valid/req_ready/req_addr fetch request to the I-cache
//   rsp_valid/rsp_inst/rsp_err   I-cache response (one per request)
//   icache_flush/_flush_done     invalidate-all handshake
//   out_*                        head of the fetch buffer toward IDU
//   redirect_cnt                 saturating count of accepted redirects
//   btb_upd_*                    predictor update, one cycle after a
//                                jump/branch redirect
module ysyx_ifu_seq #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(32'h8000_0000),
    parameter int               FBUF_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wbu_flush_pipe,
    input  logic [XLEN-1:0] wbu_cpc,
    input  logic [XLEN-1:0] wbu_rpc,
    input  logic            wbu_jen,
    input  logic            wbu_ben,
    input  logic            wbu_fence_i,
    input  logic            wbu_fence_time,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_inst,
    input  logic            rsp_err,
    output logic            icache_flush,
    input  logic            icache_flush_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pnpc,
    output logic            out_trap,
    output logic [31:0]     redirect_cnt,
    output logic            btb_upd_valid,
    output logic [XLEN-1:0] btb_upd_pc,
    output logic [XLEN-1:0] btb_upd_tgt
);

    localparam int PW = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_FLUSH_REQ  = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic            outstanding_q;
    logic            req_epoch_q;
    logic            epoch_q;
    logic            halt_q;
    logic            flush_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     redirect_cnt_q;
    logic            btb_valid_q;
    logic [XLEN-1:0] btb_pc_q;
    logic [XLEN-1:0] btb_tgt_q;

    logic [31:0]     fb_inst_q [FBUF_DEPTH];
    logic [XLEN-1:0] fb_pc_q   [FBUF_DEPTH];
    logic [XLEN-1:0] fb_pnpc_q [FBUF_DEPTH];
    logic            fb_trap_q [FBUF_DEPTH];

    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;
    logic flush_go;

    // Timing fences need nothing beyond an ordinary redirect.
    logic unused_fence_time;
    assign unused_fence_time = wbu_fence_time;

    // Issue only with nothing in flight and a guaranteed FIFO slot for the
    // reply. This credit rule is the only thing that prevents overflow.
    assign req_valid = !reset && (state_q == ST_FETCH) && !outstanding_q
                       && !halt_q && (count_q < CW'(FBUF_DEPTH));
    assign req_addr  = pc_q;
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && outstanding_q;
    // A reply is kept only if no redirect happened since it was issued
    // and none is happening now.
    assign push      = rsp_fire && (req_epoch_q == epoch_q) && !wbu_flush_pipe;
    assign pop       = out_valid && out_ready;
    // A fence.i redirect in the same cycle restarts the flush sequence
    // instead of firing the pulse.
    assign flush_go  = (state_q == ST_FLUSH_REQ) && !outstanding_q
                       && !(wbu_flush_pipe && wbu_fence_i);

    always_comb begin
        pc_d = pc_q;
        if (wbu_flush_pipe) begin
            pc_d = {wbu_cpc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            req_pc_q       <= '0;
            outstanding_q  <= 1'b0;
            req_epoch_q    <= 1'b0;
            epoch_q        <= 1'b0;
            halt_q         <= 1'b0;
            flush_q        <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            redirect_cnt_q <= '0;
            btb_valid_q    <= 1'b0;
            btb_pc_q       <= '0;
            btb_tgt_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            flush_q     <= flush_go;
            btb_valid_q <= wbu_flush_pipe && (wbu_jen || wbu_ben);

            if (req_fire) begin
                outstanding_q <= 1'b1;
                req_epoch_q   <= epoch_q;
                req_pc_q      <= pc_q;
            end else if (rsp_fire) begin
                outstanding_q <= 1'b0;
            end

            case (state_q)
                ST_FLUSH_REQ:  if (flush_go) state_q <= ST_FLUSH_WAIT;
                ST_FLUSH_WAIT: if (icache_flush_done) state_q <= ST_FETCH;
                default:       ;
            endcase

            if (wbu_flush_pipe) begin
                epoch_q   <= ~epoch_q;
                halt_q    <= 1'b0;
                btb_pc_q  <= wbu_rpc;
                btb_tgt_q <= wbu_cpc;
                if (redirect_cnt_q != '1) begin
                    redirect_cnt_q <= redirect_cnt_q + 32'd1;
                end
                // A plain redirect leaves any flush in progress untouched.
                if (wbu_fence_i) begin
                    state_q <= ST_FLUSH_REQ;
                end
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                // A faulting fetch stops the stream until software redirects.
                if (push && rsp_err) begin
                    halt_q <= 1'b1;
                end
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Fetch buffer storage, one register set per entry.
    for (genvar gi = 0; gi < FBUF_DEPTH; gi++) begin : g_fb
        always_ff @(posedge clock) begin
            if (reset) begin
                fb_inst_q[gi] <= '0;
                fb_pc_q[gi]   <= '0;
                fb_pnpc_q[gi] <= '0;
                fb_trap_q[gi] <= 1'b0;
            end else if (push && (wr_ptr_q == PW'(gi))) begin
                fb_inst_q[gi] <= rsp_inst;
                fb_pc_q[gi]   <= req_pc_q;
                fb_pnpc_q[gi] <= req_pc_q + XLEN'(4);
                fb_trap_q[gi] <= rsp_err;
            end
        end
    end

    assign out_valid     = (count_q != '0);
    assign out_inst      = fb_inst_q[rd_ptr_q];
    assign out_pc        = fb_pc_q[rd_ptr_q];
    assign out_pnpc      = fb_pnpc_q[rd_ptr_q];
    assign out_trap      = fb_trap_q[rd_ptr_q];
    // Masked by reset so the pulse disappears in the reset cycle itself.
    assign icache_flush  = flush_q && !reset;
    assign redirect_cnt  = redirect_cnt_q;
    assign btb_upd_valid = btb_valid_q;
    assign btb_upd_pc    = btb_pc_q;
    assign btb_upd_tgt   = btb_tgt_q;

endmodule

// File: tb/tb_ysyx_ifu_seq.sv
// Testbench for ysyx_ifu_seq. An I-cache model answers requests and
// acknowledges invalidates. The stimulus process queues the instructions
// it expects IDU to see, and a monitor pops and compares them as they are
// handed over.
module tb_ysyx_ifu_seq;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wbu_flush_pipe = 1'b0;
    logic [31:0] wbu_cpc = '0;
    logic [31:0] wbu_rpc = '0;
    logic        wbu_jen = 1'b0;
    logic        wbu_ben = 1'b0;
    logic        wbu_fence_i = 1'b0;
    logic        wbu_fence_time = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        icache_flush;
    logic        icache_flush_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pnpc;
    logic        out_trap;
    logic [31:0] redirect_cnt;
    logic        btb_upd_valid;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_tgt;

    always #5 clock = ~clock;

    ysyx_ifu_seq #(.XLEN(32), .RESET_PC(RST_PC), .FBUF_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .wbu_flush_pipe(wbu_flush_pipe), .wbu_cpc(wbu_cpc), .wbu_rpc(wbu_rpc),
        .wbu_jen(wbu_jen), .wbu_ben(wbu_ben), .wbu_fence_i(wbu_fence_i),
        .wbu_fence_time(wbu_fence_time),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .icache_flush(icache_flush), .icache_flush_done(icache_flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pnpc(out_pnpc), .out_trap(out_trap),
        .redirect_cnt(redirect_cnt), .btb_upd_valid(btb_upd_valid),
        .btb_upd_pc(btb_upd_pc), .btb_upd_tgt(btb_upd_tgt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // I-cache model controls and observations
    int          cyc          = 0;
    int          grants       = 0;
    bit          rsp_hold     = 1'b0;
    bit          done_en      = 1'b1;
    logic [31:0] err_addr     = 32'hFFFF_FFFC;
    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    int          done_cyc     = -1;
    int          flush_pulses = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        trap;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // I-cache model: samples at the falling edge, drives just after the
    // rising edge. Each instruction word is the bitwise inverse of its address.
    initial begin : icache_model
        logic        acc, fl, prev_fl, pend, rst_s;
        logic [31:0] a, pend_addr;
        int          done_cnt;
        prev_fl = 1'b0; pend = 1'b0; pend_addr = '0; done_cnt = 0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0; rsp_err = 1'b0;
        icache_flush_done = 1'b0;
        forever begin
            @(negedge clock);
            acc   = req_valid && req_ready && !reset;
            a     = req_addr;
            fl    = icache_flush;
            rst_s = reset;
            if (fl) begin
                check("flush_while_busy", {31'd0, pend | rsp_valid}, 32'd0);
                check("flush_width", {31'd0, prev_fl}, 32'd0);
            end
            if (fl && !prev_fl) flush_pulses++;
            prev_fl = fl;
            @(posedge clock);
            #1;
            cyc++;
            rsp_valid = 1'b0;
            rsp_err = 1'b0;
            icache_flush_done = 1'b0;
            if (rst_s) begin
                pend = 1'b0;
                done_cnt = 0;
            end
            if (acc) begin
                pend = 1'b1;
                pend_addr = a;
                acc_q.push_back(a);
                acc_cyc_q.push_back(cyc);
                if (grants > 0) grants--;
            end
            if (pend && !rsp_hold) begin
                rsp_valid = 1'b1;
                rsp_inst  = ~pend_addr;
                rsp_err   = (pend_addr == err_addr);
                pend      = 1'b0;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0 && done_en) begin
                    icache_flush_done = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (fl) done_cnt = 3;
            req_ready = (grants > 0);
        end
    end

    // Monitor: every handover to IDU is compared against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got pc 0x%08h, expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("out: pc=0x%08h inst=0x%08h trap=%0d", out_pc, out_inst, out_trap);
                    check("out_pc", out_pc, e.pc);
                    check("out_pnpc", out_pnpc, e.pc + 32'd4);
                    check("out_inst", out_inst, e.inst);
                    check("out_trap", {31'd0, out_trap}, {31'd0, e.trap});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic trap);
        exp_t e;
        e.pc = pc;
        e.inst = ~pc;
        e.trap = trap;
        exp_q.push_back(e);
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, (acc_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_acc(input int idx, input logic [31:0] exp, input string name);
        if (idx < acc_q.size()) begin
            $display("req: #%0d addr=0x%08h", idx, acc_q[idx]);
            check(name, acc_q[idx], exp);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no request #%0d, expected addr 0x%08h", name, idx, exp);
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        grants = 0;
        ticks(2);
        reset = 1'b0;
        acc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic redirect(input logic [31:0] cpc, input logic [31:0] rpc,
                            input logic jen, input logic ben,
                            input logic fi, input logic ft);
        wbu_flush_pipe = 1'b1;
        wbu_cpc = cpc;
        wbu_rpc = rpc;
        wbu_jen = jen;
        wbu_ben = ben;
        wbu_fence_i = fi;
        wbu_fence_time = ft;
        tick();
        wbu_flush_pipe = 1'b0;
        wbu_jen = 1'b0;
        wbu_ben = 1'b0;
        wbu_fence_i = 1'b0;
        wbu_fence_time = 1'b0;
    endtask

    initial begin : stimulus
        int fp0;
        // Reset values
        ticks(2);
        @(negedge clock);
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_req_addr", req_addr, RST_PC);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_icache_flush", {31'd0, icache_flush}, 32'd0);
        check("rst_redirect_cnt", redirect_cnt, 32'd0);
        check("rst_btb_valid", {31'd0, btb_upd_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);

        // Streaming fetch
        expect_out(32'h8000_0000, 1'b0);
        expect_out(32'h8000_0004, 1'b0);
        expect_out(32'h8000_0008, 1'b0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        grants = 3;
        wait_acc(3, 40, "t1_acc_wait");
        ticks(6);
        drain(30);
        check_acc(0, 32'h8000_0000, "t1_req0");
        check_acc(1, 32'h8000_0004, "t1_req1");
        check_acc(2, 32'h8000_0008, "t1_req2");

        // Backpressure fills the buffer, then drains in order
        do_reset();
        out_ready = 1'b0;
        grants = 100;
        ticks(12);
        check("t2_acc_cnt", acc_q.size(), 32'd2);
        check_acc(0, 32'h8000_0000, "t2_req0");
        check_acc(1, 32'h8000_0004, "t2_req1");
        @(negedge clock);
        check("t2_req_valid_full", {31'd0, req_valid}, 32'd0);
        check("t2_out_valid_full", {31'd0, out_valid}, 32'd1);
        check("t2_head_pc", out_pc, 32'h8000_0000);
        tick();
        expect_out(32'h8000_0000, 1'b0);
        expect_out(32'h8000_0004, 1'b0);
        grants = 0;
        out_ready = 1'b1;
        ticks(4);
        drain(20);

        // Branch redirect with a request in flight
        acc_q.delete();
        acc_cyc_q.delete();
        grants = 1;
        rsp_hold = 1'b1;
        wait_acc(1, 20, "t3_acc_wait");
        check_acc(0, 32'h8000_0008, "t3_req_before");
        ticks(2);
        redirect(32'h8000_1002, 32'h8000_0008, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("t3_btb_valid", {31'd0, btb_upd_valid}, 32'd1);
        check("t3_btb_tgt", btb_upd_tgt, 32'h8000_1002);
        check("t3_btb_pc", btb_upd_pc, 32'h8000_0008);
        check("t3_redirect_cnt", redirect_cnt, 32'd1);
        check("t3_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rsp_hold = 1'b0;
        grants = 1;
        expect_out(32'h8000_1000, 1'b0);
        @(negedge clock);
        check("t3_btb_pulse_end", {31'd0, btb_upd_valid}, 32'd0);
        wait_acc(2, 20, "t3_acc_wait2");
        check_acc(1, 32'h8000_1000, "t3_req_after");
        ticks(4);
        drain(20);

        // fence.i with a request in flight
        grants = 1;
        rsp_hold = 1'b1;
        wait_acc(3, 20, "t4_acc_wait");
        check_acc(2, 32'h8000_1004, "t4_req_before");
        ticks(2);
        fp0 = flush_pulses;
        redirect(32'h8000_0100, 32'h8000_1004, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(4);
        check("t4_no_flush_while_out", flush_pulses - fp0, 32'd0);
        @(negedge clock);
        check("t4_req_valid_flush", {31'd0, req_valid}, 32'd0);
        check("t4_redirect_cnt", redirect_cnt, 32'd2);
        check("t4_btb_valid", {31'd0, btb_upd_valid}, 32'd0);
        tick();
        rsp_hold = 1'b0;
        done_en = 1'b1;
        grants = 5;
        for (int i = 0; i < 5; i++) expect_out(32'h8000_0100 + 32'(4 * i), 1'b0);
        ticks(30);
        check("t4_flush_once", flush_pulses - fp0, 32'd1);
        check_acc(3, 32'h8000_0100, "t4_req_after");
        check_acc(7, 32'h8000_0110, "t4_req_last");
        if (acc_cyc_q.size() > 3) begin
            check("t4_fetch_after_done", (acc_cyc_q[3] > done_cyc) ? 32'd1 : 32'd0, 32'd1);
        end
        drain(20);

        // Fetch access fault stops the stream until a redirect
        do_reset();
        err_addr = 32'h8000_0008;
        out_ready = 1'b1;
        grants = 10;
        expect_out(32'h8000_0000, 1'b0);
        expect_out(32'h8000_0004, 1'b0);
        expect_out(32'h8000_0008, 1'b1);
        ticks(20);
        check("t5_acc_cnt", acc_q.size(), 32'd3);
        @(negedge clock);
        check("t5_req_valid_halt", {31'd0, req_valid}, 32'd0);
        drain(20);
        tick();
        grants = 2;
        expect_out(32'h8000_0200, 1'b0);
        expect_out(32'h8000_0204, 1'b0);
        redirect(32'h8000_0200, 32'h8000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(10);
        check_acc(3, 32'h8000_0200, "t5_req_resume0");
        check_acc(4, 32'h8000_0204, "t5_req_resume1");
        check("t5_redirect_cnt", redirect_cnt, 32'd1);
        drain(20);

        // Reset in the middle of an invalidate
        done_en = 1'b0;
        redirect(32'h8000_0300, 32'h8000_0204, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        check("t6_redirect_cnt", redirect_cnt, 32'd2);
        check("t6_req_valid_flush", {31'd0, req_valid}, 32'd0);
        tick();
        reset = 1'b1;
        grants = 0;
        @(negedge clock);
        check("t6_flush_drops", {31'd0, icache_flush}, 32'd0);
        ticks(2);
        reset = 1'b0;
        acc_q.delete();
        acc_cyc_q.delete();
        @(negedge clock);
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_redirect_cnt_rst", redirect_cnt, 32'd0);
        check("t6_req_addr", req_addr, RST_PC);
        check("t6_req_valid", {31'd0, req_valid}, 32'd1);
        check("t6_icache_flush", {31'd0, icache_flush}, 32'd0);
        tick();
        grants = 1;
        done_en = 1'b1;
        expect_out(32'h8000_0000, 1'b0);
        wait_acc(1, 20, "t6_acc_wait");
        check_acc(0, 32'h8000_0000, "t6_req_after_rst");
        ticks(4);
        drain(20);

        ticks(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
